// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC six-step commutator: FSM encoding, hall codes,
// gate bit positions and the sector/direction to gate-pattern table.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] HALL_NONE = 3'b000;
  localparam logic [2:0] HALL_ALL  = 3'b111;

  localparam int PH_AH = 0;
  localparam int PH_BH = 1;
  localparam int PH_CH = 2;
  localparam int PH_AL = 3;
  localparam int PH_BL = 4;
  localparam int PH_CL = 5;

  function automatic logic hall_valid(input logic [2:0] code);
    return (code != HALL_NONE) && (code != HALL_ALL);
  endfunction

  // Forward pairs are listed as (high bit, low bit); reverse drives the same two
  // phases with high and low exchanged.
  function automatic logic [5:0] comm_pattern(input logic [2:0] sec, input logic dir);
    logic [5:0] p;
    int         hp;
    int         lp;
    p  = '0;
    hp = PH_AH;
    lp = PH_BL;
    case (sec)
      3'b101:  begin hp = PH_AH; lp = PH_BL; end
      3'b100:  begin hp = PH_AH; lp = PH_CL; end
      3'b110:  begin hp = PH_BH; lp = PH_CL; end
      3'b010:  begin hp = PH_BH; lp = PH_AL; end
      3'b011:  begin hp = PH_CH; lp = PH_AL; end
      3'b001:  begin hp = PH_CH; lp = PH_BL; end
      default: begin hp = PH_AH; lp = PH_BL; end
    endcase
    if (hall_valid(sec)) begin
      if (!dir) begin
        p[hp] = 1'b1;
        p[lp] = 1'b1;
      end else begin
        p[lp - 3] = 1'b1;
        p[hp + 3] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser for the three hall pins followed by a stability counter;
// a code is accepted after DEBOUNCE identical synchronised samples.
module hall_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_hall,
  output logic [2:0] o_code,
  output logic       o_change
);

  localparam int DB = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
  localparam int CW = $clog2(DB + 1);

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_code;
  logic          r_change;
  logic [CW-1:0] w_cnt_nxt;

  // r_cand is the previous synchronised sample; the count restarts whenever it differs.
  assign w_cnt_nxt = (r_sync2 != r_cand)   ? CW'(1) :
                     (r_cnt == CW'(DB))     ? r_cnt  : r_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_code   <= '0;
      r_change <= 1'b0;
    end else begin
      r_sync1 <= i_hall;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_cnt   <= w_cnt_nxt;
      if ((w_cnt_nxt == CW'(DB)) && (r_sync2 != r_code)) begin
        r_code   <= r_sync2;
        r_change <= 1'b1;
      end else begin
        r_change <= 1'b0;
      end
    end
  end

  assign o_code   = r_code;
  assign o_change = r_change;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step trapezoidal commutation sequencer: debounced hall sector, dead-time
// on every switch-set change, edge-aligned high-side PWM and sticky hall fault.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int PWM_PERIOD = 800,
  parameter int DEADTIME   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int DUTY_W     = 16,
  parameter int PER_W      = 24
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              dir,
  input  logic [DUTY_W-1:0] duty,
  input  logic              hall1,
  input  logic              hall2,
  input  logic              hall3,
  output logic [5:0]        PHASES,
  output logic              hall_fault,
  output logic [2:0]        sector,
  output logic [PER_W-1:0]  comm_period,
  output logic [1:0]        o_state_dbg
);

  localparam int DT = (DEADTIME < 1) ? 1 : DEADTIME;
  localparam int DW = $clog2(DT + 1);
  localparam int PW = $clog2(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_PERIOD);
  localparam logic [PER_W-1:0]  PER_MAX  = '1;

  logic [2:0]        w_sector;
  logic              w_change;
  logic              w_valid;
  logic              w_retarget;
  logic              w_pwm_on;
  logic [5:0]        w_pat;
  logic [5:0]        w_drive;

  state_t            r_state;
  logic [DW-1:0]     r_dead;
  logic [2:0]        r_tgt_sec;
  logic              r_tgt_dir;
  logic [5:0]        r_phases;
  logic              r_fault;
  logic [PW-1:0]     r_pwm;
  logic [DUTY_W-1:0] r_duty;
  logic [PER_W-1:0]  r_per_cnt;
  logic [PER_W-1:0]  r_comm;

  hall_debounce #(.DEBOUNCE(DEBOUNCE)) u_hall (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_hall  ({hall3, hall2, hall1}),
    .o_code  (w_sector),
    .o_change(w_change)
  );

  assign w_valid    = hall_valid(w_sector);
  assign w_retarget = (w_sector != r_tgt_sec) || (dir != r_tgt_dir);
  assign w_pwm_on   = 32'(r_pwm) < 32'(r_duty);
  assign w_pat      = comm_pattern(r_tgt_sec, r_tgt_dir);
  assign w_drive    = {w_pat[5:3], w_pat[2:0] & {3{w_pwm_on}}};

  // Duty is sampled only at the wrap so a period is never cut short or stretched.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_pwm  <= '0;
      r_duty <= '0;
    end else if (r_pwm == PW'(PWM_PERIOD - 1)) begin
      r_pwm  <= '0;
      r_duty <= (duty > DUTY_MAX) ? DUTY_MAX : duty;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
      r_comm    <= PER_MAX;
    end else if (w_change && w_valid) begin
      r_comm    <= (r_per_cnt == PER_MAX) ? PER_MAX : r_per_cnt + 1'b1;
      r_per_cnt <= '0;
    end else if (r_per_cnt == PER_MAX) begin
      r_comm <= PER_MAX;
    end else begin
      r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  // Gates are driven only from the latched target pair, never from the live sector.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_OFF;
      r_dead    <= '0;
      r_tgt_sec <= '0;
      r_tgt_dir <= 1'b0;
      r_phases  <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_phases <= (r_state == ST_DRIVE) ? w_drive : 6'b0;
      r_fault  <= (r_state == ST_FAULT);
      case (r_state)
        ST_OFF: begin
          if (enable) begin
            if (!w_valid) begin
              r_state <= ST_FAULT;
            end else begin
              r_state   <= ST_DEAD;
              r_dead    <= DW'(DT);
              r_tgt_sec <= w_sector;
              r_tgt_dir <= dir;
            end
          end
        end
        ST_DEAD: begin
          if (!enable) begin
            r_state <= ST_OFF;
          end else if (!w_valid) begin
            r_state <= ST_FAULT;
          end else if (w_retarget) begin
            r_dead    <= DW'(DT);
            r_tgt_sec <= w_sector;
            r_tgt_dir <= dir;
          end else if (r_dead == DW'(1)) begin
            r_state <= ST_DRIVE;
          end else begin
            r_dead <= r_dead - 1'b1;
          end
        end
        ST_DRIVE: begin
          if (!enable) begin
            r_state <= ST_OFF;
          end else if (!w_valid) begin
            r_state <= ST_FAULT;
          end else if (w_retarget) begin
            r_state   <= ST_DEAD;
            r_dead    <= DW'(DT);
            r_tgt_sec <= w_sector;
            r_tgt_dir <= dir;
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            r_state <= ST_OFF;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign PHASES      = r_phases;
  assign hall_fault  = r_fault;
  assign sector      = w_sector;
  assign comm_period = r_comm;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: hall-driven sector scoreboard, dead-time and PWM
// window measurements, fault handling, commutation period and async reset.
module tb_bldc_commutator;

  localparam int PER_W = 14;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             dir;
  logic [15:0]      duty;
  logic             hall1;
  logic             hall2;
  logic             hall3;
  logic [5:0]       phases;
  logic             hall_fault;
  logic [2:0]       sector;
  logic [PER_W-1:0] comm_period;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ovl_cnt  = 0;
  bit mon_en   = 1'b1;

  logic [2:0] exp_q[$];
  int         lat_q[$];
  logic [2:0] prev_sec;

  bldc_commutator #(
    .PWM_PERIOD(800),
    .DEADTIME  (16),
    .DEBOUNCE  (4),
    .DUTY_W    (16),
    .PER_W     (PER_W)
  ) dut (
    .CLK        (clk),
    .reset      (rst),
    .enable     (enable),
    .dir        (dir),
    .duty       (duty),
    .hall1      (hall1),
    .hall2      (hall2),
    .hall3      (hall3),
    .PHASES     (phases),
    .hall_fault (hall_fault),
    .sector     (sector),
    .comm_period(comm_period),
    .o_state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive_hall(input logic [2:0] code);
    {hall3, hall2, hall1} = code;
  endtask

  task automatic set_hall(input logic [2:0] code);
    drive_hall(code);
    exp_q.push_back(code);
    lat_q.push_back(cyc);
  endtask

  task automatic wait_sector(input logic [2:0] code);
    int n = 0;
    while (sector != code && n < 50) begin
      step(1);
      n++;
    end
    check("sector_wait", 32'(sector), 32'(code));
  endtask

  task automatic zero_run(output int lead, output int len);
    lead = 0;
    while (phases != 6'b0 && lead < 100) begin
      step(1);
      lead++;
    end
    len = 0;
    while (phases == 6'b0 && len < 100) begin
      step(1);
      len++;
    end
  endtask

  task automatic window(input int n, input int bit_i, output int on_cnt,
                        output logic [5:0] or_m, output logic [5:0] and_m);
    on_cnt = 0;
    or_m   = '0;
    and_m  = '1;
    for (int i = 0; i < n; i++) begin
      if (phases[bit_i]) on_cnt++;
      or_m  = or_m | phases;
      and_m = and_m & phases;
      step(1);
    end
  endtask

  // scoreboard: each accepted sector must match the next queued hall code, 6 cycles after the pin change
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_sec = sector;
    end else if (sector != prev_sec) begin
      if (exp_q.size() == 0) begin
        check("sector_unexpected", 32'(sector), 32'(prev_sec));
      end else begin
        check("sector", 32'(sector), 32'(exp_q.pop_front()));
        check("sector_latency", 32'(cyc - lat_q.pop_front()), 32'd6);
      end
      prev_sec = sector;
    end
    if ((phases[2:0] & phases[5:3]) != 3'b0) ovl_cnt++;
  end

  int         lead;
  int         len;
  int         on_cnt;
  logic [5:0] or_m;
  logic [5:0] and_m;
  int         n;

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    dir    = 1'b0;
    duty   = 16'd400;
    drive_hall(3'b000);
    step(3);
    check("rst_phases", 32'(phases), 32'd0);
    check("rst_fault", 32'(hall_fault), 32'd0);
    check("rst_sector", 32'(sector), 32'd0);
    check("rst_period", 32'(comm_period), 32'h3FFF);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // start-up at sector 101 forward: A+B-
    set_hall(3'b101);
    wait_sector(3'b101);
    step(2);
    enable = 1'b1;
    zero_run(lead, len);
    check("start_lead", 32'(lead), 32'd0);
    check("start_dead", 32'(len), 32'd18);
    step(900);
    window(800, 0, on_cnt, or_m, and_m);
    check("t1_ah_on", 32'(on_cnt), 32'd400);
    check("t1_or", 32'(or_m), 32'b010001);
    check("t1_and", 32'(and_m), 32'b010000);

    // commutate to 100: A+C-
    set_hall(3'b100);
    wait_sector(3'b100);
    zero_run(lead, len);
    check("t2_lead", 32'(lead), 32'd2);
    check("t2_dead", 32'(len), 32'd16);
    window(800, 0, on_cnt, or_m, and_m);
    check("t2_ah_on", 32'(on_cnt), 32'd400);
    check("t2_or", 32'(or_m), 32'b100001);
    check("t2_and", 32'(and_m), 32'b100000);
    drive_hall(3'b101);
    step(3);
    drive_hall(3'b100);
    step(20);
    check("glitch_sector", 32'(sector), 32'b100);
    check("glitch_cl", 32'(phases[5]), 32'd1);

    // back to 101, then reverse: B+A-
    set_hall(3'b101);
    wait_sector(3'b101);
    zero_run(lead, len);
    check("t5_back_dead", 32'(len), 32'd16);
    dir = 1'b1;
    zero_run(lead, len);
    check("dir_lead", 32'(lead), 32'd2);
    check("dir_dead", 32'(len), 32'd16);
    window(800, 1, on_cnt, or_m, and_m);
    check("rev_bh_on", 32'(on_cnt), 32'd400);
    check("rev_or", 32'(or_m), 32'b001010);
    check("rev_and", 32'(and_m), 32'b001000);
    dir = 1'b0;
    zero_run(lead, len);
    check("dir_back_dead", 32'(len), 32'd16);

    // duty limits and mid-period update
    duty = 16'd1000;
    step(1700);
    window(800, 0, on_cnt, or_m, and_m);
    check("duty_max_on", 32'(on_cnt), 32'd800);
    duty = 16'd0;
    step(1700);
    window(800, 0, on_cnt, or_m, and_m);
    check("duty_zero_on", 32'(on_cnt), 32'd0);
    duty = 16'd800;
    n = 0;
    while (!phases[0] && n < 1700) begin
      step(1);
      n++;
    end
    on_cnt = 0;
    while (phases[0] && on_cnt < 2000) begin
      on_cnt++;
      if (on_cnt == 100) duty = 16'd200;
      step(1);
    end
    check("duty_mid_on", 32'(on_cnt), 32'd1000);
    n = 0;
    while (!phases[0] && n < 2000) begin
      n++;
      step(1);
    end
    check("duty_mid_off", 32'(n), 32'd600);
    duty = 16'd400;

    // invalid hall latches fault until enable drops
    set_hall(3'b111);
    wait_sector(3'b111);
    step(3);
    check("fault_phases", 32'(phases), 32'd0);
    check("fault_flag", 32'(hall_fault), 32'd1);
    check("fault_state", 32'(state_dbg), 32'd3);
    set_hall(3'b101);
    wait_sector(3'b101);
    step(20);
    check("fault_sticky", 32'(hall_fault), 32'd1);
    check("fault_sticky_ph", 32'(phases), 32'd0);
    enable = 1'b0;
    step(3);
    check("fault_clear", 32'(hall_fault), 32'd0);
    check("fault_off_state", 32'(state_dbg), 32'd0);
    enable = 1'b1;
    zero_run(lead, len);
    check("restart_dead", 32'(len), 32'd18);

    // commutation period, then stall saturation
    set_hall(3'b100);
    step(5000);
    set_hall(3'b110);
    wait_sector(3'b110);
    step(1);
    check("comm_period", 32'(comm_period), 32'd5000);
    step(16500);
    check("comm_stall", 32'(comm_period), 32'h3FFF);
    check("b_c_low", 32'(phases[5:3]), 32'b100);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("overlap", 32'(ovl_cnt), 32'd0);

    // asynchronous reset while driving
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_phases", 32'(phases), 32'd0);
    check("async_rst_sector", 32'(sector), 32'd0);
    step(2);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
